entropy_sequencer: RTL

ENTROPY_SEQUENCER -- requirements
Module: entropy_sequencer

---
 rtl/entropy_pkg.sv | 27 ++
 rtl/entropy_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/entropy_pkg.sv
// Shared types and symbol encodings for the entropy sequencer.
// Holds the FSM state enum, EOB/ZRL encodings and the default block size.
package entropy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DC   = 2'd1,
        ST_AC   = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int BLOCK_COEFS_DEF = 64;

    localparam logic [3:0] EOB_RUN  = 4'd0;
    localparam logic [4:0] EOB_SIZE = 5'd0;
    localparam logic [3:0] ZRL_RUN  = 4'd15;
    localparam logic [4:0] ZRL_SIZE = 5'd0;

    function automatic logic is_eob(input logic [3:0] run, input logic [4:0] size);
        return (run == EOB_RUN) && (size == EOB_SIZE);
    endfunction

    function automatic logic is_zrl(input logic [3:0] run, input logic [4:0] size);
        return (run == ZRL_RUN) && (size == ZRL_SIZE);
    endfunction

endpackage

// File: rtl/entropy_sequencer.sv
// Purpose: walks run/size symbols through DC/AC block positions and frames them for the decoder.
// Latency: one cycle from symbol accept (or frame start) to every registered output.
// Backpressure: none downstream; upstream ready is high whenever a frame is active, ERR drains.
module entropy_sequencer
    import entropy_pkg::*;
#(
    parameter int BLOCK_COEFS = BLOCK_COEFS_DEF,
    parameter int BLK_CNT_W   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_start_in,
    input  logic [BLK_CNT_W-1:0] blocks_in,
    input  logic                 sym_valid_in,
    output logic                 sym_ready_out,
    input  logic [3:0]           sym_run_in,
    input  logic [4:0]           sym_size_in,
    input  logic [10:0]          sym_value_in,
    output logic [10:0]          value_out,
    output logic [5:0]           run_out,
    output logic [4:0]           size_out,
    output logic                 valid_out,
    output logic                 dc_out,
    output logic                 pred_clear_out,
    output logic                 block_done_out,
    output logic                 frame_done_out,
    output logic                 error_out,
    output logic                 busy_out
);

    localparam logic [6:0] COEFS7 = 7'(BLOCK_COEFS);

    state_t               state_q, state_d;
    logic [6:0]           pos_q, pos_d, pos_next;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d, blk_inc;
    logic [BLK_CNT_W-1:0] blocks_q, blocks_d;
    logic                 err_q, err_d;
    logic                 act_q, act_d;
    logic                 vld_q, vld_d;
    logic                 dc_q, dc_d;
    logic                 pc_q, pc_d;
    logic                 bd_q, bd_d;
    logic                 fd_q, fd_d;
    logic [5:0]           run_q, run_d;
    logic [4:0]           size_q, size_d;
    logic [10:0]          val_q, val_d;
    logic                 accept;
    logic                 blk_end;

    assign accept = sym_valid_in && act_q;
    assign blk_inc = blk_cnt_q + 1'b1;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            blk_cnt_q <= '0;
            blocks_q  <= '0;
            err_q     <= 1'b0;
            act_q     <= 1'b0;
            vld_q     <= 1'b0;
            dc_q      <= 1'b0;
            pc_q      <= 1'b0;
            bd_q      <= 1'b0;
            fd_q      <= 1'b0;
            run_q     <= '0;
            size_q    <= '0;
            val_q     <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            blk_cnt_q <= blk_cnt_d;
            blocks_q  <= blocks_d;
            err_q     <= err_d;
            act_q     <= act_d;
            vld_q     <= vld_d;
            dc_q      <= dc_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            fd_q      <= fd_d;
            run_q     <= run_d;
            size_q    <= size_d;
            val_q     <= val_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        pos_next  = pos_q;
        blk_cnt_d = blk_cnt_q;
        blocks_d  = blocks_q;
        err_d     = err_q;
        vld_d     = 1'b0;
        dc_d      = 1'b0;
        pc_d      = 1'b0;
        bd_d      = 1'b0;
        fd_d      = 1'b0;
        run_d     = run_q;
        size_d    = size_q;
        val_d     = val_q;
        blk_end   = 1'b0;

        if (frame_start_in) begin
            // Frame start outranks any symbol handshaken in the same cycle.
            blocks_d  = blocks_in;
            pos_d     = '0;
            blk_cnt_d = '0;
            err_d     = 1'b0;
            pc_d      = 1'b1;
            if (blocks_in == '0) begin
                fd_d    = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_DC;
            end
        end else if (accept) begin
            unique case (state_q)
                ST_DC: begin
                    vld_d    = 1'b1;
                    dc_d     = 1'b1;
                    run_d    = '0;
                    size_d   = sym_size_in;
                    val_d    = sym_value_in;
                    pos_next = 7'd1;
                    pos_d    = pos_next;
                    state_d  = ST_AC;
                    blk_end  = (pos_next == COEFS7);
                end
                ST_AC: begin
                    if (is_eob(sym_run_in, sym_size_in)) begin
                        blk_end = 1'b1;
                    end else begin
                        if (is_zrl(sym_run_in, sym_size_in))
                            pos_next = pos_q + 7'd16;
                        else
                            pos_next = pos_q + {3'b000, sym_run_in} + 7'd1;
                        if (pos_next > COEFS7) begin
                            err_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            if (!is_zrl(sym_run_in, sym_size_in)) begin
                                vld_d  = 1'b1;
                                run_d  = {2'b00, sym_run_in};
                                size_d = sym_size_in;
                                val_d  = sym_value_in;
                            end
                            pos_d   = pos_next;
                            blk_end = (pos_next == COEFS7);
                        end
                    end
                end
                default: ;
            endcase

            if (blk_end) begin
                bd_d      = 1'b1;
                blk_cnt_d = blk_inc;
                pos_d     = '0;
                if (blk_inc == blocks_q) begin
                    fd_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DC;
                end
            end
        end

        act_d = (state_d != ST_IDLE);
    end

    assign sym_ready_out  = act_q;
    assign busy_out       = act_q;
    assign error_out      = err_q;
    assign valid_out      = vld_q;
    assign dc_out         = dc_q;
    assign pred_clear_out = pc_q;
    assign block_done_out = bd_q;
    assign frame_done_out = fd_q;
    assign run_out        = run_q;
    assign size_out       = size_q;
    assign value_out      = val_q;

endmodule
